picorv32_wb_master: RTL

Bus initiator converting the picorv32 native memory interface (valid/ready) into single pipelined Wishbone B4 transactions toward the SoC Wishbone interconnect. It owns the CPU side of the bus. It latches each CPU request, drives CYC/STB until the request is accepted, then waits for ACK/ERR. It returns data to the CPU and reports bus errors, including a no-response timeout, through sticky error outputs.

---
 rtl/picorv32_wb_master_pkg.sv | 24 ++
 rtl/picorv32_wb_master_timeout.sv | 33 +++
 rtl/picorv32_wb_master.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/picorv32_wb_master_pkg.sv
// Shared definitions for the picorv32 -> Wishbone bus initiator.
//   wbm_state_e    : initiator FSM state encoding
//   SLV_*_BASE     : slave address map of the SoC interconnect
//   wb_sel_of()    : byte selects derived from the CPU write strobes
package picorv32_wb_master_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } wbm_state_e;

    localparam logic [31:0] SLV_SRAM_BASE = 32'h0000_0000;
    localparam logic [31:0] SLV_LED_BASE  = 32'h8000_0000;
    localparam logic [31:0] SLV_UART_BASE = 32'h8000_0008;
    localparam logic [31:0] SLV_CDT_BASE  = 32'h8000_0010;

    // Reads fetch the whole word; writes select only the strobed bytes.
    function automatic logic [3:0] wb_sel_of(input logic [3:0] wstrb);
        return (|wstrb) ? wstrb : 4'hF;
    endfunction

endpackage

// File: rtl/picorv32_wb_master_timeout.sv
// No-response watchdog for one Wishbone transfer.
//   i_clk, i_resetn : clock, async active-low reset
//   i_clr           : restart the count (start of a transfer)
//   i_en            : count this cycle (transfer outstanding)
//   o_expired       : count has reached LIMIT
module wb_timeout_counter #(
    parameter int W     = 16,
    parameter int LIMIT = 255
) (
    input  logic i_clk,
    input  logic i_resetn,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam logic [W-1:0] LIMIT_W = W'(LIMIT);

    logic [W-1:0] cnt;

    // Saturates at LIMIT so a long-abandoned count never wraps back to "alive".
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn)
            cnt <= '0;
        else if (i_clr)
            cnt <= '0;
        else if (i_en && cnt != LIMIT_W)
            cnt <= cnt + 1'b1;
    end

    assign o_expired = (cnt == LIMIT_W);

endmodule

// File: rtl/picorv32_wb_master.sv
// picorv32 native memory port -> single pipelined Wishbone B4 transfers.
// One request at a time: latch, strobe until accepted, wait for ACK/ERR
// (or timeout), pulse o_mem_ready for one cycle, then one dead cycle.
//   i_mem_*        : CPU request (valid/instr/addr/wdata/wstrb)
//   o_mem_ready/rdata : completion pulse and read data
//   o_wb_* / i_wb_*: Wishbone initiator signals
//   i_bus_err_clr  : clears the sticky error capture
//   o_bus_err*     : sticky first-error flag, address, fetch flag, timeout flag
module picorv32_wb_master
    import picorv32_wb_master_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TIMEOUT_W      = 16
) (
    input  logic        i_clk,
    input  logic        i_resetn,
    input  logic        i_mem_valid,
    input  logic        i_mem_instr,
    input  logic [31:0] i_mem_addr,
    input  logic [31:0] i_mem_wdata,
    input  logic [3:0]  i_mem_wstrb,
    output logic        o_mem_ready,
    output logic [31:0] o_mem_rdata,
    output logic [31:0] o_wb_addr,
    output logic [31:0] o_wb_data,
    output logic [3:0]  o_wb_sel,
    output logic        o_wb_we,
    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    input  logic        i_wb_ack,
    input  logic [31:0] i_wb_data,
    input  logic        i_wb_stall,
    input  logic        i_wb_err,
    input  logic        i_bus_err_clr,
    output logic        o_bus_err,
    output logic [31:0] o_bus_err_addr,
    output logic        o_bus_err_instr,
    output logic        o_bus_err_timeout
);

    wbm_state_e  state_q, state_d;
    logic        instr_q, instr_d;
    logic        cyc_d, stb_d, we_d, ready_d;
    logic [31:0] addr_d, data_d, rdata_d;
    logic [3:0]  sel_d;
    logic        err_d, err_instr_d, err_tmo_d;
    logic [31:0] err_addr_d;
    logic        tmo_clr, tmo_en, tmo_expired;
    logic        resp, complete, cmpl_err, cmpl_tmo;

    assign tmo_en = (state_q == ST_REQ) || (state_q == ST_WAIT);

    wb_timeout_counter #(
        .W     (TIMEOUT_W),
        .LIMIT (TIMEOUT_CYCLES)
    ) u_tmo (
        .i_clk     (i_clk),
        .i_resetn  (i_resetn),
        .i_clr     (tmo_clr),
        .i_en      (tmo_en),
        .o_expired (tmo_expired)
    );

    always_comb begin
        state_d  = state_q;
        instr_d  = instr_q;
        cyc_d    = o_wb_cyc;
        stb_d    = o_wb_stb;
        addr_d   = o_wb_addr;
        data_d   = o_wb_data;
        sel_d    = o_wb_sel;
        we_d     = o_wb_we;
        ready_d  = 1'b0;
        rdata_d  = 32'h0;
        tmo_clr  = 1'b0;
        resp     = 1'b0;
        complete = 1'b0;
        cmpl_err = 1'b0;
        cmpl_tmo = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_mem_valid) begin
                    addr_d  = i_mem_addr;
                    data_d  = i_mem_wdata;
                    instr_d = i_mem_instr;
                    we_d    = |i_mem_wstrb;
                    sel_d   = wb_sel_of(i_mem_wstrb);
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                    tmo_clr = 1'b1;
                    state_d = ST_REQ;
                end
            end
            ST_REQ, ST_WAIT: begin
                // A response while the strobe is still stalled belongs to no
                // accepted request, so it only counts once stall is low.
                resp = (i_wb_ack || i_wb_err) &&
                       ((state_q == ST_WAIT) || !i_wb_stall);
                if (resp) begin
                    complete = 1'b1;
                    cmpl_err = i_wb_err;          // ERR wins over ACK
                end else if (tmo_expired) begin
                    complete = 1'b1;
                    cmpl_err = 1'b1;
                    cmpl_tmo = 1'b1;
                end

                if (complete) begin
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                    ready_d = 1'b1;
                    rdata_d = (!cmpl_err && !o_wb_we) ? i_wb_data : 32'h0;
                    state_d = ST_DONE;
                end else if (state_q == ST_REQ && !i_wb_stall) begin
                    stb_d   = 1'b0;
                    state_d = ST_WAIT;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Sticky error capture: clear first, so an error landing in the same
    // cycle as a clear is what remains captured.
    always_comb begin
        err_d       = o_bus_err;
        err_addr_d  = o_bus_err_addr;
        err_instr_d = o_bus_err_instr;
        err_tmo_d   = o_bus_err_timeout;
        if (i_bus_err_clr) begin
            err_d       = 1'b0;
            err_addr_d  = 32'h0;
            err_instr_d = 1'b0;
            err_tmo_d   = 1'b0;
        end
        if (complete && cmpl_err && (!o_bus_err || i_bus_err_clr)) begin
            err_d       = 1'b1;
            err_addr_d  = o_wb_addr;
            err_instr_d = instr_q;
            err_tmo_d   = cmpl_tmo;
        end
    end

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            state_q           <= ST_IDLE;
            instr_q           <= 1'b0;
            o_wb_cyc          <= 1'b0;
            o_wb_stb          <= 1'b0;
            o_wb_addr         <= 32'h0;
            o_wb_data         <= 32'h0;
            o_wb_sel          <= 4'h0;
            o_wb_we           <= 1'b0;
            o_mem_ready       <= 1'b0;
            o_mem_rdata       <= 32'h0;
            o_bus_err         <= 1'b0;
            o_bus_err_addr    <= 32'h0;
            o_bus_err_instr   <= 1'b0;
            o_bus_err_timeout <= 1'b0;
        end else begin
            state_q           <= state_d;
            instr_q           <= instr_d;
            o_wb_cyc          <= cyc_d;
            o_wb_stb          <= stb_d;
            o_wb_addr         <= addr_d;
            o_wb_data         <= data_d;
            o_wb_sel          <= sel_d;
            o_wb_we           <= we_d;
            o_mem_ready       <= ready_d;
            o_mem_rdata       <= rdata_d;
            o_bus_err         <= err_d;
            o_bus_err_addr    <= err_addr_d;
            o_bus_err_instr   <= err_instr_d;
            o_bus_err_timeout <= err_tmo_d;
        end
    end

endmodule
